// File: rtl/router_pkg.sv
// Shared constants for the router packet FIFO: header length-field layout and tracker width.
package router_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned LEN_MSB      = 7;
  localparam int unsigned LEN_LSB      = 2;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned PARITY_BEATS = 1;

  typedef logic [LEN_W-1:0] len_t;

  // Words still to come after a header: payload length plus the trailing parity beat.
  function automatic len_t hdr_rem(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB] + len_t'(PARITY_BEATS);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-pointer storage for the packet FIFO: write port, registered read port and a
// combinational view of the word at the read pointer.
module router_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W:0]   wdata,
  output logic [DATA_W:0]   head,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Contents are deliberately left uninitialised on reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) begin
        rd_data <= mem[rd_ptr][DATA_W-1:0];
        rd_ptr  <= rd_ptr + 1'b1;
      end else begin
        rd_data <= '0;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Router packet FIFO with header-driven length tracking and end-of-packet pulse.
// Define ROUTER_PKT_FIFO_ERR_EN to build the sticky protocol-error flag.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   soft_reset,
  input  logic                   write_enb,
  input  logic                   read_enb,
  input  logic                   lfd_state,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   pkt_end,
  output logic                   err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FullLvl = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvl   = CW'(AF_LEVEL);

  logic              we;
  logic              re;
  logic [DATA_W:0]   head;
  logic              head_tag;
  logic [DATA_W-1:0] rd_data;
  len_t              rem;

  assign full        = (count == FullLvl);
  assign empty       = (count == '0);
  assign almost_full = (count >= AfLvl);

  // Flush wins over any same-cycle transfer.
  assign we       = write_enb && !full && !soft_reset;
  assign re       = read_enb && !empty && !soft_reset;
  assign head_tag = head[DATA_W];
  assign data_out = rd_data;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .flush   (soft_reset),
    .we      (we),
    .re      (re),
    .wdata   ({lfd_state, data_in}),
    .head    (head),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      rem        <= '0;
      data_valid <= 1'b0;
      pkt_end    <= 1'b0;
    end else if (soft_reset) begin
      count      <= '0;
      rem        <= '0;
      data_valid <= 1'b0;
      pkt_end    <= 1'b0;
    end else begin
      data_valid <= re;
      pkt_end    <= re && !head_tag && (rem == len_t'(1));
      if (re) begin
        if (head_tag)        rem <= hdr_rem(head[7:0]);
        else if (rem != '0)  rem <= rem - 1'b1;
      end
      case ({we, re})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_PKT_FIFO_ERR_EN
  logic err_set;

  // Dropped write, ignored read, header inside a packet, or payload outside one.
  assign err_set = (write_enb && full) || (read_enb && empty) ||
                   (re && head_tag && (rem != '0)) || (re && !head_tag && (rem == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           err <= 1'b0;
    else if (soft_reset) err <= 1'b0;
    else if (err_set)    err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: a reference queue model predicts every read word,
// its end-of-packet marker, the occupancy flags and the error flag.
module tb_router_pkt_fifo;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       pkt_end;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] mq[$];  // model storage {tag, data}
  logic [8:0] sb[$];  // expected outputs {pkt_end, data}
  int         mrem = 0;
  bit         merr = 0;

  router_pkt_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .pkt_end     (pkt_end),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int  n;
    bit  exp_err;
    n = mq.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == 16));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= 14));
`ifdef ROUTER_PKT_FIFO_ERR_EN
    exp_err = merr;
`else
    exp_err = 1'b0;
`endif
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] d,
                      input bit sr);
    bit         rd_ok;
    bit         wr_ok;
    bit         pe;
    logic [8:0] w;
    logic [8:0] e;
    int         n;
    @(negedge clock);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = d;
    soft_reset = sr;
    n     = mq.size();
    rd_ok = re && (n != 0) && !sr;
    wr_ok = we && (n != 16) && !sr;
    if (sr) begin
      mq.delete();
      mrem = 0;
      merr = 1'b0;
    end else begin
      if (we && n == 16) merr = 1'b1;
      if (re && n == 0)  merr = 1'b1;
    end
    if (rd_ok) begin
      w  = mq.pop_front();
      pe = 1'b0;
      if (w[8]) begin
        if (mrem != 0) merr = 1'b1;
        mrem = (int'(w[7:2]) + 1) % 64;
      end else begin
        pe = (mrem == 1);
        if (mrem == 0) merr = 1'b1;
        else mrem = mrem - 1;
      end
      sb.push_back({pe, w[7:0]});
    end
    if (wr_ok) mq.push_back({lfd, d});
    @(posedge clock);
    #1;
    if (rd_ok) begin
      e = sb.pop_front();
      check("data_valid", 32'(data_valid), 32'd1);
      check("data_out", 32'(data_out), 32'(e[7:0]));
      check("pkt_end", 32'(pkt_end), 32'(e[8]));
    end else begin
      check("data_valid_idle", 32'(data_valid), 32'd0);
      check("data_out_idle", 32'(data_out), 32'd0);
      check("pkt_end_idle", 32'(pkt_end), 32'd0);
    end
    check_flags();
  endtask

  task automatic wr(input bit lfd, input logic [7:0] d);
    step(1'b1, 1'b0, lfd, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    #12;
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_pkt_end", 32'(pkt_end), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check_flags();
    @(negedge clock);
    reset = 1'b0;

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h10 + i));
    wr(1'b0, 8'hFF);
    // Read and write at full: read accepted, write dropped.
    step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    for (int i = 0; i < 15; i++) rd();
    // Read and write at empty: write accepted, read ignored.
    step(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
    rd();
    rd();

    // Flush clears err; then a well-formed packet of length 3.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'h31);
    wr(1'b0, 8'h32);
    wr(1'b0, 8'h33);
    wr(1'b0, 8'h5A);
    for (int i = 0; i < 5; i++) rd();

    // Zero-length header: the next word is parity and ends the packet.
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h77);
    rd();
    rd();

    // Continuous streaming through the pointer wrap.
    r = 8'($urandom_range(0, 255));
    wr(1'b0, r);
    for (int i = 1; i < 40; i++) begin
      r = 8'($urandom_range(0, 255));
      step(1'b1, 1'b1, 1'b0, r, 1'b0);
    end
    rd();

    // Flush mid-packet with a read in flight, then track a fresh length-1 packet.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'h41);
    wr(1'b0, 8'h42);
    rd();
    rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    wr(1'b1, 8'h04);
    wr(1'b0, 8'h51);
    wr(1'b0, 8'h52);
    rd();
    rd();
    rd();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
